// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronises rxd, deserialises LSB-first frames and hands
// each byte to the consumer on a valid/ready handshake, flagging framing errors and overrun.
module uart_rx #(
  parameter int BAUD_RATE      = 9600,
  parameter int CLK_FREQ       = 50000000,
  parameter int COUNT_ONE_BIT  = CLK_FREQ / BAUD_RATE,
  parameter int COUNT_HALF_BIT = COUNT_ONE_BIT / 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxd,
  output logic [7:0] data_out,
  output logic       data_valid,
  input  logic       data_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } state_t;

  localparam logic [15:0] ONE_M1  = 16'(COUNT_ONE_BIT - 1);
  localparam logic [15:0] HALF_M1 = 16'(COUNT_HALF_BIT - 1);

  state_t      r_state;
  state_t      w_stateNext;
  logic [15:0] r_cnt;
  logic [15:0] w_cntNext;
  logic [2:0]  r_bitIdx;
  logic [2:0]  w_bitIdxNext;
  logic [7:0]  r_shift;
  logic [7:0]  w_shiftNext;
  logic        r_sync1;
  logic        r_sync2;
  logic        w_rxS;
  logic        w_deliver;
  logic        w_frameErrSet;
  logic        w_load;
  logic        w_overrunSet;
  logic [7:0]  r_dataOut;
  logic        r_dataValid;
  logic        r_frameErr;
  logic        r_overrun;

  // Two-flop synchroniser, preset high so reset looks like an idle line
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rxd;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rxS = r_sync2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Counter clears on every transition and every sample, so each compare
  // below measures time since the previous decision point.
  always_comb begin
    w_stateNext   = r_state;
    w_cntNext     = r_cnt + 16'd1;
    w_bitIdxNext  = r_bitIdx;
    w_shiftNext   = r_shift;
    w_deliver     = 1'b0;
    w_frameErrSet = 1'b0;
    case (r_state)
      IDLE: begin
        w_cntNext = 16'd0;
        if (!w_rxS) begin
          w_stateNext = START;
        end
      end
      START: begin
        if (r_cnt == HALF_M1) begin
          w_cntNext = 16'd0;
          if (!w_rxS) begin
            w_stateNext  = DATA;
            w_bitIdxNext = 3'd0;
          end else begin
            w_stateNext = IDLE;
          end
        end
      end
      DATA: begin
        if (r_cnt == ONE_M1) begin
          w_cntNext   = 16'd0;
          w_shiftNext = {w_rxS, r_shift[7:1]};
          if (r_bitIdx == 3'd7) begin
            w_stateNext = STOP;
          end else begin
            w_bitIdxNext = r_bitIdx + 3'd1;
          end
        end
      end
      STOP: begin
        if (r_cnt == ONE_M1) begin
          w_cntNext = 16'd0;
          if (w_rxS) begin
            w_deliver   = 1'b1;
            w_stateNext = IDLE;
          end else begin
            w_frameErrSet = 1'b1;
            w_stateNext   = BREAK;
          end
        end
      end
      BREAK: begin
        w_cntNext = 16'd0;
        if (w_rxS) begin
          w_stateNext = IDLE;
        end
      end
      default: begin
        w_cntNext   = 16'd0;
        w_stateNext = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= 16'd0;
      r_bitIdx <= 3'd0;
      r_shift  <= 8'h00;
    end else begin
      r_cnt    <= w_cntNext;
      r_bitIdx <= w_bitIdxNext;
      r_shift  <= w_shiftNext;
    end
  end

  // A completed byte may replace the held one only if it is being accepted now
  assign w_load       = w_deliver & (~r_dataValid | data_ready);
  assign w_overrunSet = w_deliver & r_dataValid & ~data_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dataOut   <= 8'h00;
      r_dataValid <= 1'b0;
      r_frameErr  <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frameErr <= w_frameErrSet;
      r_overrun  <= w_overrunSet;
      if (w_load) begin
        r_dataOut   <= r_shift;
        r_dataValid <= 1'b1;
      end else if (r_dataValid && data_ready) begin
        r_dataValid <= 1'b0;
      end
    end
  end

  assign data_out   = r_dataOut;
  assign data_valid = r_dataValid;
  assign frame_err  = r_frameErr;
  assign overrun    = r_overrun;
  assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit: normal frames, overrun,
// start glitch, break, mid-frame reset and +/-3% baud skew.
module tb_uart_rx;

  localparam int HALF_CLK = 50;
  localparam int BIT_T    = 1600;

  logic       clk;
  logic       rst_n;
  logic       rxd;
  logic [7:0] data_out;
  logic       data_valid;
  logic       data_ready;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int nAsserts = 0;
  int nFails   = 0;

  int         cycleCnt = 0;
  int         startCycle = 0;
  int         lastRiseCycle = 0;
  int         validRises = 0;
  int         validCycles = 0;
  int         accCnt = 0;
  logic [7:0] accData [0:63];
  int         frameErrCycles = 0;
  int         overrunCycles = 0;
  int         bothCycles = 0;
  int         holdViol = 0;
  logic       prevValid = 1'b0;
  logic       prevReady = 1'b0;
  logic [7:0] prevData = 8'h00;

  int baseAcc, baseRise, baseValidCyc, baseFe, baseOv;

  uart_rx #(
    .BAUD_RATE (10),
    .CLK_FREQ  (160)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rxd        (rxd),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  initial begin
    clk = 1'b0;
    forever #HALF_CLK clk = ~clk;
  end

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  // Event monitor: records handshakes and pulses on the falling edge, where
  // inputs driven just after a rising edge are already stable.
  always @(negedge clk) begin
    if (data_valid && !prevValid) begin
      validRises    = validRises + 1;
      lastRiseCycle = cycleCnt;
    end
    if (data_valid) validCycles = validCycles + 1;
    if (data_valid && prevValid && !prevReady && (data_out !== prevData))
      holdViol = holdViol + 1;
    if (data_valid && data_ready) begin
      accData[accCnt[5:0]] = data_out;
      accCnt = accCnt + 1;
    end
    if (frame_err) frameErrCycles = frameErrCycles + 1;
    if (overrun) overrunCycles = overrunCycles + 1;
    if (frame_err && overrun) bothCycles = bothCycles + 1;
    prevValid = data_valid;
    prevReady = data_ready;
    prevData  = data_out;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAsserts = nAsserts + 1;
    assert (obs === exp) else begin
      nFails = nFails + 1;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #10;
  endtask

  task automatic snapshot();
    baseAcc      = accCnt;
    baseRise     = validRises;
    baseValidCyc = validCycles;
    baseFe       = frameErrCycles;
    baseOv       = overrunCycles;
  endtask

  // Drives one 8N1 frame with the given bit period; the line is left at the stop level
  task automatic applyStimulus(input logic [7:0] b, input int bitT, input logic stopBit);
    @(posedge clk);
    #10;
    startCycle = cycleCnt;
    rxd = 1'b0;
    #bitT;
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      #bitT;
    end
    rxd = stopBit;
    #bitT;
  endtask

  initial begin
    rst_n      = 1'b0;
    rxd        = 1'b1;
    data_ready = 1'b0;
    #333;
    checkOutput("reset_data_out", 32'(data_out), 32'h00);
    checkOutput("reset_valid", 32'(data_valid), 32'h0);
    checkOutput("reset_frame_err", 32'(frame_err), 32'h0);
    checkOutput("reset_overrun", 32'(overrun), 32'h0);
    checkOutput("reset_busy", 32'(busy), 32'h0);
    waitCycles(1);
    rst_n = 1'b1;
    waitCycles(10);
    checkOutput("post_reset_valid", 32'(validRises), 32'd0);

    $display("[TB] single frame 0xA5, ready high");
    data_ready = 1'b1;
    snapshot();
    applyStimulus(8'hA5, BIT_T, 1'b1);
    waitCycles(40);
    checkOutput("a5_accepted", 32'(accCnt - baseAcc), 32'd1);
    checkOutput("a5_data", 32'(accData[baseAcc]), 32'hA5);
    checkOutput("a5_valid_cycles", 32'(validCycles - baseValidCyc), 32'd1);
    checkOutput("a5_latency_ok", 32'((lastRiseCycle - startCycle >= 154) && (lastRiseCycle - startCycle <= 156)), 32'd1);
    checkOutput("a5_frame_err", 32'(frameErrCycles - baseFe), 32'd0);
    checkOutput("a5_overrun", 32'(overrunCycles - baseOv), 32'd0);
    checkOutput("a5_busy_idle", 32'(busy), 32'h0);

    $display("[TB] back-to-back 0x3C/0xC3 with ready low");
    data_ready = 1'b0;
    snapshot();
    applyStimulus(8'h3C, BIT_T, 1'b1);
    applyStimulus(8'hC3, BIT_T, 1'b1);
    waitCycles(40);
    checkOutput("ovr_valid_held", 32'(data_valid), 32'h1);
    checkOutput("ovr_data_held", 32'(data_out), 32'h3C);
    checkOutput("ovr_pulse_count", 32'(overrunCycles - baseOv), 32'd1);
    checkOutput("ovr_frame_err", 32'(frameErrCycles - baseFe), 32'd0);
    checkOutput("ovr_none_accepted", 32'(accCnt - baseAcc), 32'd0);
    data_ready = 1'b1;
    waitCycles(1);
    checkOutput("ovr_valid_dropped", 32'(data_valid), 32'h0);
    checkOutput("ovr_accepted", 32'(accCnt - baseAcc), 32'd1);
    checkOutput("ovr_accepted_data", 32'(accData[baseAcc]), 32'h3C);
    waitCycles(20);
    checkOutput("ovr_c3_never_shown", 32'(validRises - baseRise), 32'd1);

    $display("[TB] 4-clock start glitch");
    snapshot();
    @(posedge clk);
    #10;
    rxd = 1'b0;
    waitCycles(4);
    rxd = 1'b1;
    waitCycles(1);
    checkOutput("glitch_busy_in_start", 32'(busy), 32'h1);
    waitCycles(20);
    checkOutput("glitch_busy_cleared", 32'(busy), 32'h0);
    checkOutput("glitch_no_valid", 32'(validRises - baseRise), 32'd0);
    checkOutput("glitch_no_frame_err", 32'(frameErrCycles - baseFe), 32'd0);
    checkOutput("glitch_no_overrun", 32'(overrunCycles - baseOv), 32'd0);

    $display("[TB] 0x55 with low stop bit, line held low");
    snapshot();
    applyStimulus(8'h55, BIT_T, 1'b0);
    waitCycles(40 * 16);
    checkOutput("break_frame_err_cycles", 32'(frameErrCycles - baseFe), 32'd1);
    checkOutput("break_no_valid", 32'(validRises - baseRise), 32'd0);
    checkOutput("break_busy", 32'(busy), 32'h1);
    rxd = 1'b1;
    waitCycles(5);
    checkOutput("break_exit_idle", 32'(busy), 32'h0);
    snapshot();
    applyStimulus(8'h81, BIT_T, 1'b1);
    waitCycles(20);
    checkOutput("after_break_accepted", 32'(accCnt - baseAcc), 32'd1);
    checkOutput("after_break_data", 32'(accData[baseAcc]), 32'h81);
    checkOutput("after_break_frame_err", 32'(frameErrCycles - baseFe), 32'd0);

    $display("[TB] reset during data bit 4 of 0xFF");
    snapshot();
    @(posedge clk);
    #10;
    rxd = 1'b0;
    #BIT_T;
    rxd = 1'b1;
    #(4 * BIT_T + BIT_T / 2);
    checkOutput("rst_busy_before", 32'(busy), 32'h1);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_data_out", 32'(data_out), 32'h00);
    checkOutput("rst_valid", 32'(data_valid), 32'h0);
    checkOutput("rst_busy", 32'(busy), 32'h0);
    checkOutput("rst_frame_err", 32'(frame_err), 32'h0);
    checkOutput("rst_overrun", 32'(overrun), 32'h0);
    #299;
    rst_n = 1'b1;
    waitCycles(20 * 16);
    checkOutput("rst_no_spurious_valid", 32'(validRises - baseRise), 32'd0);
    checkOutput("rst_no_frame_err", 32'(frameErrCycles - baseFe), 32'd0);
    checkOutput("rst_no_overrun", 32'(overrunCycles - baseOv), 32'd0);
    snapshot();
    applyStimulus(8'h12, BIT_T, 1'b1);
    waitCycles(20);
    checkOutput("after_rst_accepted", 32'(accCnt - baseAcc), 32'd1);
    checkOutput("after_rst_data", 32'(accData[baseAcc]), 32'h12);

    $display("[TB] +/-3 percent baud skew");
    snapshot();
    applyStimulus(8'h00, 1648, 1'b1);
    waitCycles(32);
    applyStimulus(8'hFF, 1552, 1'b1);
    waitCycles(32);
    applyStimulus(8'h00, 1552, 1'b1);
    waitCycles(32);
    applyStimulus(8'hFF, 1648, 1'b1);
    waitCycles(32);
    checkOutput("skew_accepted", 32'(accCnt - baseAcc), 32'd4);
    checkOutput("skew_data0", 32'(accData[baseAcc]), 32'h00);
    checkOutput("skew_data1", 32'(accData[baseAcc + 1]), 32'hFF);
    checkOutput("skew_data2", 32'(accData[baseAcc + 2]), 32'h00);
    checkOutput("skew_data3", 32'(accData[baseAcc + 3]), 32'hFF);
    checkOutput("skew_frame_err", 32'(frameErrCycles - baseFe), 32'd0);
    checkOutput("skew_overrun", 32'(overrunCycles - baseOv), 32'd0);

    checkOutput("data_held_while_valid", 32'(holdViol), 32'd0);
    checkOutput("err_and_overrun_exclusive", 32'(bothCycles), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receive stage that sits directly upstream of the ANN input path, on the side opposite the UART transmit FSM.
- Deserialises 8N1 frames (LSB first) from the serial input pin and presents each byte on a valid/ready handshake to the consumer (input buffer / ANN loader).
- Detects framing errors, start-bit glitches and overrun. Shares baud parameters with the transmitter.

Parameters:
- BAUD_RATE, 9600, serial bit rate.
- CLK_FREQ, 50000000, clock frequency in Hz.
- COUNT_ONE_BIT, CLK_FREQ/BAUD_RATE, clocks per bit. Must be >= 4 and < 65536.
- COUNT_HALF_BIT, COUNT_ONE_BIT/2, clocks from start-edge detection to the start-bit mid-sample (integer division).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous reset, active-low
- rxd  input  1  serial line, idle high, asynchronous to clk
- data_out  output  8  received byte; held stable while data_valid=1
- data_valid  output  1  byte available
- data_ready  input  1  consumer accepts byte when data_valid&data_ready at a rising clk edge
- frame_err  output  1  one-cycle pulse: stop bit sampled low
- overrun  output  1  one-cycle pulse: new byte completed while previous one is still unaccepted
- busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE, counter=0, bit index=0, shift register=0.
  - data_out=8'h00; data_valid, frame_err, overrun and busy all 0.
  - Synchroniser flops preset to 1 (idle line).
  - Reset mid-frame abandons the frame. No output pulses are generated on reset release.
- Input sync: rxd passes through a 2-flop synchroniser (rx_s). All decisions use rx_s, giving 2 cycles of latency.
- Counter: 16-bit. It resets to 0 on every state transition and on every bit sample.
- State machine:
  - IDLE: rx_s==0 -> START, counter=0.
  - START: at counter==COUNT_HALF_BIT-1, sample rx_s.
    - 0 -> DATA, bit index=0.
    - 1 -> IDLE (glitch rejected, no pulses).
  - DATA: at counter==COUNT_ONE_BIT-1, shift rx_s into the MSB of the shift register (right shift, so the first bit ends up in bit 0).
    - After the 8th sample -> STOP. Otherwise increment bit index.
  - STOP: at counter==COUNT_ONE_BIT-1, sample rx_s.
    - 1 -> deliver the byte (see below), then IDLE.
    - 0 -> frame_err=1 for one cycle, discard the byte, go to BREAK.
  - BREAK: wait for rx_s==1 -> IDLE. This prevents a held-low line from being decoded as repeated 0x00 frames.
- Deliver:
  - If data_valid==0, or data_valid&data_ready in the same cycle: data_out<=shift register, data_valid<=1.
  - Otherwise: keep the old byte, overrun=1 for one cycle, drop the new byte.
- Handshake:
  - data_valid deasserts the cycle after data_valid&data_ready.
  - data_out does not change while data_valid=1.
  - data_ready while data_valid=0 has no effect.
- Latency:
  - Falling edge on rxd to data_valid=1 is 2 + COUNT_HALF_BIT + 9*COUNT_ONE_BIT cycles (+/-1 for edge phase).
  - The receiver is back in IDLE half a bit before the stop-bit end, so back-to-back frames with zero idle are received.
- frame_err and overrun never assert in the same cycle.

Test Plan (CLK_FREQ=160, BAUD_RATE=10 -> COUNT_ONE_BIT=16, COUNT_HALF_BIT=8):
- Send 0xA5 at 16 clk/bit with data_ready=1 -> data_valid pulses 1 cycle, data_out=8'hA5, about 154 cycles after the start edge; frame_err=0, overrun=0.
- Send 0x3C then 0xC3 back-to-back with data_ready=0, then raise data_ready -> data_out=8'h3C held and accepted; overrun pulses once at the end of the second frame; 0xC3 is never presented.
- Pulse rxd low for 4 clocks only -> START aborts at the mid-sample; busy returns to 0; no data_valid, frame_err or overrun.
- Send 0x55 with the stop bit driven low and the line held low for 40 bit times -> exactly one frame_err pulse, no data_valid, state remains BREAK until rxd=1; the next valid frame 0x81 is received correctly.
- Send 0xFF and assert rst_n=0 during data bit 4 for 3 cycles -> all outputs 0 immediately; after release with the line idle, no spurious byte; a following 0x12 is received correctly.
- Send 0x00 and 0xFF with the bit period skewed +/-3% -> both bytes received exactly, with no errors.
